// File: rtl/ldpc_fp_pkg.sv
// Shared fixed-point / floating-point definitions for the LDPC decoder datapath.
package ldpc_fp_pkg;

    localparam int FIX_W   = 15;  // unsigned fixed-point message width
    localparam int EXP_W   = 7;   // exponent width
    localparam int MAN_W   = 10;  // mantissa width
    localparam int EXP_MIN = 2;   // exponent used when no bit above the mantissa field is set

    // Normalised value: sign is always 0 for the unsigned inputs handled here.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mantissa;
    } fp_t;

endpackage

// File: rtl/fix_norm_comb.sv
// Combinational leading-one normaliser: unsigned fixed-point in, fp_t out.
// The top MAN_W-wide window starting at the leading one becomes the mantissa;
// inputs with no bit set above the mantissa field pass through unshifted with EXP_MIN.
module fix_norm_comb
    import ldpc_fp_pkg::*;
#(
    parameter int IN_W = FIX_W
) (
    input  logic [IN_W-1:0] x,
    output fp_t             y
);

    // Scan upward so the highest set bit above the mantissa field wins.
    always_comb begin
        y.sign     = 1'b0;
        y.exp      = EXP_W'(EXP_MIN);
        y.mantissa = x[MAN_W-1:0];
        for (int k = MAN_W; k < IN_W; k++) begin
            if (x[k]) begin
                y.exp      = EXP_W'(k - MAN_W + EXP_MIN + 1);
                y.mantissa = x[k -: MAN_W];
            end
        end
    end

endmodule

// File: rtl/fix2float_rr_sched.sv
// Round-robin scheduler sharing one fixed-to-float normaliser among N_REQ
// requesters. S1 captures the granted request, S2 holds the normalised result
// together with the tag of its requester until the downstream side takes it.
module fix2float_rr_sched #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 15,
    parameter int EXP_W = 7,
    parameter int MAN_W = 10,
    parameter int TAG_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*IN_W-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W-1:0]        out_exp,
    output logic [MAN_W-1:0]        out_mantissa,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);

    import ldpc_fp_pkg::*;

    // Pipeline state
    logic               s1_vld_reg;
    logic [IN_W-1:0]    s1_data_reg;
    logic [TAG_W-1:0]   s1_tag_reg;
    logic               s2_vld_reg;
    fp_t                s2_fp_reg;
    logic [TAG_W-1:0]   s2_tag_reg;
    logic [TAG_W-1:0]   last_grant_reg;
    logic [CNT_W-1:0]   done_cnt_reg;

    // Combinational control
    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               deliver;
    logic [N_REQ-1:0]   grant_vec;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   scan_idx;
    logic               grant_found;
    fp_t                s1_fp;
    logic [IN_W-1:0]    req_word [N_REQ];

    // A stage may advance when it is empty or its contents are leaving this cycle.
    assign s2_adv  = !s2_vld_reg || out_ready;
    assign s1_adv  = !s1_vld_reg || s2_adv;
    assign deliver = s2_vld_reg && out_ready;
    assign accept  = |req_ready;

    // Per-requester data slicing and gated accept strobes.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*IN_W +: IN_W];
            assign req_ready[gi] = grant_vec[gi] && s1_adv;
        end
    endgenerate

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vec   = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = last_grant_reg;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = (scan_idx == TAG_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found         = 1'b1;
                grant_idx           = scan_idx;
                grant_vec[scan_idx] = 1'b1;
            end
        end
    end

    // Normaliser sits between S1 and S2.
    fix_norm_comb #(
        .IN_W (IN_W)
    ) u_norm (
        .x (s1_data_reg),
        .y (s1_fp)
    );

    // S1: capture the granted request and remember who was served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_reg     <= 1'b0;
            s1_data_reg    <= '0;
            s1_tag_reg     <= '0;
            last_grant_reg <= TAG_W'(N_REQ - 1);
        end else if (accept) begin
            s1_vld_reg     <= 1'b1;
            s1_data_reg    <= req_word[grant_idx];
            s1_tag_reg     <= grant_idx;
            last_grant_reg <= grant_idx;
        end else if (s1_adv) begin
            s1_vld_reg     <= 1'b0;
        end
    end

    // S2: load the normalised S1 contents whenever the output slot frees up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_reg <= 1'b0;
            s2_fp_reg  <= '0;
            s2_tag_reg <= '0;
        end else if (s2_adv) begin
            s2_vld_reg <= s1_vld_reg;
            s2_fp_reg  <= s1_fp;
            s2_tag_reg <= s1_tag_reg;
        end
    end

    // Delivered-result counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt_reg <= '0;
        end else if (deliver) begin
            done_cnt_reg <= done_cnt_reg + 1'b1;
        end
    end

    assign out_valid    = s2_vld_reg;
    assign out_sign     = s2_fp_reg.sign;
    assign out_exp      = s2_fp_reg.exp;
    assign out_mantissa = s2_fp_reg.mantissa;
    assign out_tag      = s2_tag_reg;
    assign busy         = s1_vld_reg || s2_vld_reg;
    assign done_cnt     = done_cnt_reg;

endmodule

// File: tb/tb_fix2float_rr_sched.sv
// Directed testbench for fix2float_rr_sched: single conversions, round-robin
// streaming, backpressure, mid-flight reset and counter wrap (narrow instance).
module tb_fix2float_rr_sched;

    localparam int N_REQ = 4;
    localparam int IN_W  = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ*IN_W-1:0] req_data = '0;
    logic               out_ready = 1'b0;

    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic               out_sign;
    logic [6:0]         out_exp;
    logic [9:0]         out_mantissa;
    logic [1:0]         out_tag;
    logic               busy;
    logic [15:0]        done_cnt;

    logic [N_REQ-1:0]   w_req_ready;
    logic               w_out_valid;
    logic               w_out_sign;
    logic [6:0]         w_out_exp;
    logic [9:0]         w_out_mantissa;
    logic [1:0]         w_out_tag;
    logic               w_busy;
    logic [3:0]         w_done_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fix2float_rr_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mantissa (out_mantissa),
        .out_tag      (out_tag),
        .busy         (busy),
        .done_cnt     (done_cnt)
    );

    // Narrow-counter instance sharing the same stimulus.
    fix2float_rr_sched #(.CNT_W(4)) dut_w (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (w_req_ready),
        .out_valid    (w_out_valid),
        .out_ready    (out_ready),
        .out_sign     (w_out_sign),
        .out_exp      (w_out_exp),
        .out_mantissa (w_out_mantissa),
        .out_tag      (w_out_tag),
        .busy         (w_busy),
        .done_cnt     (w_done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [14:0] d);
        req_data[i*IN_W +: IN_W] = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated conversion through requester i.
    task automatic single(input int i, input logic [14:0] d, input logic [6:0] e, input logic [9:0] m);
        set_data(i, d);
        req_valid = 4'(1 << i);
        out_ready = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'(1) << i);
        tick();
        req_valid = '0;
        tick();
        $display("[TB] single req=%0d data=%h -> valid=%0b exp=%0d man=%h tag=%0d",
                 i, d, out_valid, out_exp, out_mantissa, out_tag);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_exp",   32'(out_exp), 32'(e));
        check("single_man",   32'(out_mantissa), 32'(m));
        check("single_tag",   32'(out_tag), 32'(i));
        check("single_sign",  32'(out_sign), 32'd0);
        tick();
        check("single_drain", 32'(out_valid), 32'd0);
    endtask

    logic [6:0] exp_tab [4];
    logic [9:0] man_tab [4];
    int accepts;

    initial begin
        exp_tab[0] = 7'd7; man_tab[0] = 10'h200;   // 15'h4000
        exp_tab[1] = 7'd3; man_tab[1] = 10'h200;   // 15'h0400
        exp_tab[2] = 7'd2; man_tab[2] = 10'h3FF;   // 15'h03FF
        exp_tab[3] = 7'd7; man_tab[3] = 10'h3FF;   // 15'h7FFF

        // Reset state
        do_reset();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_exp",   32'(out_exp), 32'd0);
        check("rst_man",   32'(out_mantissa), 32'd0);
        check("rst_tag",   32'(out_tag), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_cnt",   32'(done_cnt), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single requests and value sweep
        single(0, 15'h4000, 7'd7, 10'h200);
        check("cnt_after_first", 32'(done_cnt), 32'd1);
        single(2, 15'h0000, 7'd2, 10'h000);
        single(1, 15'h0400, 7'd3, 10'h200);
        single(3, 15'h03FF, 7'd2, 10'h3FF);
        single(0, 15'h7FFF, 7'd7, 10'h3FF);
        check("cnt_after_sweep", 32'(done_cnt), 32'd5);

        // Round-robin streaming with all four requesting
        do_reset();
        set_data(0, 15'h4000);
        set_data(1, 15'h0400);
        set_data(2, 15'h03FF);
        set_data(3, 15'h7FFF);
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 2) begin
                $display("[TB] stream cycle=%0d out tag=%0d exp=%0d man=%h", c, out_tag, out_exp, out_mantissa);
                check("rr_valid", 32'(out_valid), 32'd1);
                check("rr_tag",   32'(out_tag), 32'((c - 2) % 4));
                check("rr_exp",   32'(out_exp), 32'(exp_tab[(c - 2) % 4]));
                check("rr_man",   32'(out_mantissa), 32'(man_tab[(c - 2) % 4]));
            end
            tick();
        end
        check("rr_cnt_mid", 32'(done_cnt), 32'd8);
        req_valid = '0;
        tick();
        tick();
        tick();
        check("rr_cnt_end", 32'(done_cnt), 32'd10);
        check("rr_idle",    32'(busy), 32'd0);

        // Backpressure: requesters 1 and 2, output stalled for 5 cycles
        do_reset();
        set_data(1, 15'h1234);
        set_data(2, 15'h0800);
        req_valid = 4'b0110;
        out_ready = 1'b0;
        accepts   = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            accepts += $countones(req_ready);
            if (c == 0) check("bp_grant0", 32'(req_ready), 32'b0010);
            if (c == 1) check("bp_grant1", 32'(req_ready), 32'b0100);
            if (c >= 2) begin
                check("bp_stall_ready", 32'(req_ready), 32'd0);
                check("bp_hold_valid",  32'(out_valid), 32'd1);
                check("bp_hold_tag",    32'(out_tag), 32'd1);
                check("bp_hold_man",    32'(out_mantissa), 32'h246);
            end
            tick();
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        $display("[TB] release out tag=%0d exp=%0d man=%h", out_tag, out_exp, out_mantissa);
        check("bp_out1_tag", 32'(out_tag), 32'd1);
        check("bp_out1_exp", 32'(out_exp), 32'd5);
        tick();
        $display("[TB] release out tag=%0d exp=%0d man=%h", out_tag, out_exp, out_mantissa);
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2_tag",   32'(out_tag), 32'd2);
        check("bp_out2_exp",   32'(out_exp), 32'd4);
        check("bp_out2_man",   32'(out_mantissa), 32'h200);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_cnt",   32'(done_cnt), 32'd2);

        // Reset while both stages hold data
        set_data(0, 15'h0001);
        set_data(1, 15'h0002);
        req_valid = 4'b0011;
        out_ready = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_cnt",   32'(done_cnt), 32'd0);
        req_valid = 4'hF;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // Counter wrap on the 4-bit instance
        do_reset();
        set_data(0, 15'h0100);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 17; c++) tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        $display("[TB] wrap done_cnt=%0d narrow done_cnt=%0d", done_cnt, w_done_cnt);
        check("wrap_wide",   32'(done_cnt), 32'd17);
        check("wrap_narrow", 32'(w_done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
